zxuno_regport: RTL and testbench

Second-generation ZX-Uno register-port controller, between the Z80 I/O bus and the core's internal register slaves. It holds the 8-bit register index written through the address port. It turns level-sensitive Z80 I/O cycles on the data port into single-clock read and write strobes, with a latched write byte. It returns either the index or slave read data to the CPU, and optionally auto-increments the index after each data-port access for block transfers.

---
 rtl/zxuno_regport_if.sv | 27 ++
 rtl/zxuno_regport.sv | 126 ++++++++++++
 tb/tb_zxuno_regport.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/zxuno_regport_if.sv
// rtl/zxuno_regport_if.sv - Z80 I/O bus and register-slave signals of the ZX-Uno register port
interface zxuno_regport_if;
    logic [15:0] a;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe;
    logic [7:0]  addr;
    logic        addr_chg;
    logic [7:0]  reg_rdata;
    logic [7:0]  reg_wdata;
    logic        reg_rd;
    logic        reg_rd_stb;
    logic        reg_wr_stb;

    modport slave (
        input  a, iorq_n, rd_n, wr_n, din, reg_rdata,
        output dout, oe, addr, addr_chg, reg_wdata, reg_rd, reg_rd_stb, reg_wr_stb
    );

    modport master (
        output a, iorq_n, rd_n, wr_n, din, reg_rdata,
        input  dout, oe, addr, addr_chg, reg_wdata, reg_rd, reg_rd_stb, reg_wr_stb
    );
endinterface

// File: rtl/zxuno_regport.sv
// rtl/zxuno_regport.sv - ZX-Uno register-port controller (index/data ports, read/write strobes)
// Define ZXUNO_REGPORT_AUTOINC_EN to decode the control port and enable index auto-increment.
module zxuno_regport (
    input  logic            clk,
    input  logic            rst_n,
    zxuno_regport_if.slave  bus
);
    localparam logic [15:0] IOADDR = 16'hFC3B;
    localparam logic [15:0] IODATA = 16'hFD3B;

    logic       w_io_rd;
    logic       w_io_wr;
    logic       w_addr_wr;
    logic       w_addr_rd;
    logic       w_data_rd;
    logic       w_data_wr;
    logic       w_addr_wr_rise;
    logic       w_data_rd_rise;
    logic       w_data_wr_rise;
    logic       w_data_end;
    logic       w_autoinc;
    logic       w_ctrl_rd;

    logic [7:0] r_addr;
    logic       r_addr_chg;
    logic [7:0] r_wdata;
    logic       r_rd_stb;
    logic       r_wr_stb;
    logic       r_prev_addr_wr;
    logic       r_prev_data_rd;
    logic       r_prev_data_wr;

    assign w_io_rd   = !bus.iorq_n && !bus.rd_n;
    assign w_io_wr   = !bus.iorq_n && !bus.wr_n;
    assign w_addr_wr = w_io_wr && (bus.a == IOADDR);
    assign w_addr_rd = w_io_rd && (bus.a == IOADDR);
    assign w_data_rd = w_io_rd && (bus.a == IODATA);
    assign w_data_wr = w_io_wr && (bus.a == IODATA);

    assign w_addr_wr_rise = w_addr_wr && !r_prev_addr_wr;
    assign w_data_rd_rise = w_data_rd && !r_prev_data_rd;
    assign w_data_wr_rise = w_data_wr && !r_prev_data_wr;
    // End of a data-port access: the index advances only once the slave is done with it.
    assign w_data_end     = (r_prev_data_rd && !w_data_rd) || (r_prev_data_wr && !w_data_wr);

`ifdef ZXUNO_REGPORT_AUTOINC_EN
    localparam logic [15:0] IOCTRL = 16'hFE3B;

    logic w_ctrl_wr;
    logic r_prev_ctrl_wr;
    logic r_autoinc;

    assign w_ctrl_wr = w_io_wr && (bus.a == IOCTRL);
    assign w_ctrl_rd = w_io_rd && (bus.a == IOCTRL);
    assign w_autoinc = r_autoinc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev_ctrl_wr <= 1'b0;
            r_autoinc      <= 1'b0;
        end else begin
            r_prev_ctrl_wr <= w_ctrl_wr;
            if (w_ctrl_wr && !r_prev_ctrl_wr) begin
                r_autoinc <= bus.din[0];
            end
        end
    end
`else
    assign w_ctrl_rd = 1'b0;
    assign w_autoinc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr         <= 8'h00;
            r_addr_chg     <= 1'b1;
            r_wdata        <= 8'h00;
            r_rd_stb       <= 1'b0;
            r_wr_stb       <= 1'b0;
            r_prev_addr_wr <= 1'b0;
            r_prev_data_rd <= 1'b0;
            r_prev_data_wr <= 1'b0;
        end else begin
            r_prev_addr_wr <= w_addr_wr;
            r_prev_data_rd <= w_data_rd;
            r_prev_data_wr <= w_data_wr;
            r_rd_stb       <= w_data_rd_rise;
            r_wr_stb       <= w_data_wr_rise;
            if (w_data_wr_rise) begin
                r_wdata <= bus.din;
            end
            // An explicit index write beats a coincident end-of-access increment.
            if (w_addr_wr_rise) begin
                r_addr     <= bus.din;
                r_addr_chg <= 1'b1;
            end else if (w_autoinc && w_data_end) begin
                r_addr     <= r_addr + 8'd1;
                r_addr_chg <= 1'b1;
            end else begin
                r_addr_chg <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.dout = r_addr;
        bus.oe   = 1'b0;
        if (w_addr_rd) begin
            bus.dout = r_addr;
            bus.oe   = 1'b1;
        end else if (w_data_rd) begin
            bus.dout = bus.reg_rdata;
            bus.oe   = 1'b1;
        end else if (w_ctrl_rd) begin
            bus.dout = {7'b0, w_autoinc};
            bus.oe   = 1'b1;
        end
    end

    assign bus.addr       = r_addr;
    assign bus.addr_chg   = r_addr_chg;
    assign bus.reg_wdata  = r_wdata;
    assign bus.reg_rd     = w_data_rd;
    assign bus.reg_rd_stb = r_rd_stb;
    assign bus.reg_wr_stb = r_wr_stb;
endmodule

// File: tb/tb_zxuno_regport.sv
// tb/tb_zxuno_regport.sv - table-driven scoreboard bench for zxuno_regport
module tb_zxuno_regport;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    zxuno_regport_if bus ();

    zxuno_regport dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef ZXUNO_REGPORT_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    localparam int OP_I = 0;
    localparam int OP_O = 1;
    localparam int OP_N = 2;

    typedef struct {
        logic        rst;
        int          op;
        logic [15:0] a;
        logic [7:0]  din;
        logic [7:0]  rdata;
        logic [7:0]  e_dout;
        logic        e_oe;
        logic [7:0]  e_addr;
        logic        e_chg;
        logic [7:0]  e_wd;
        logic        e_rd;
        logic        e_rs;
        logic        e_ws;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   vec_idx = 0;

    function automatic vec_t mk(input logic rst, input int op, input logic [15:0] a,
                                input logic [7:0] din, input logic [7:0] rdata,
                                input logic [7:0] e_dout, input logic e_oe,
                                input logic [7:0] e_addr, input logic e_chg,
                                input logic [7:0] e_wd, input logic e_rd,
                                input logic e_rs, input logic e_ws);
        vec_t v;
        v.rst = rst; v.op = op; v.a = a; v.din = din; v.rdata = rdata;
        v.e_dout = e_dout; v.e_oe = e_oe; v.e_addr = e_addr; v.e_chg = e_chg;
        v.e_wd = e_wd; v.e_rd = e_rd; v.e_rs = e_rs; v.e_ws = e_ws;
        return v;
    endfunction

    task automatic cmp(input string field, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL v%0d.%s: got %02h expected %02h", vec_idx, field, act, exp);
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        rst_n         = v.rst;
        bus.a         = v.a;
        bus.din       = v.din;
        bus.reg_rdata = v.rdata;
        bus.iorq_n    = (v.op == OP_I);
        bus.rd_n      = (v.op != OP_N);
        bus.wr_n      = (v.op != OP_O);
        sb.push_back(v);
        #2;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL v%0d.scoreboard: got empty queue expected entry", vec_idx);
        end else begin
            e = sb.pop_front();
            cmp("dout",     bus.dout,                e.e_dout);
            cmp("oe",       {7'b0, bus.oe},          {7'b0, e.e_oe});
            cmp("addr",     bus.addr,                e.e_addr);
            cmp("addr_chg", {7'b0, bus.addr_chg},    {7'b0, e.e_chg});
            cmp("wdata",    bus.reg_wdata,           e.e_wd);
            cmp("reg_rd",   {7'b0, bus.reg_rd},      {7'b0, e.e_rd});
            cmp("rd_stb",   {7'b0, bus.reg_rd_stb},  {7'b0, e.e_rs});
            cmp("wr_stb",   {7'b0, bus.reg_wr_stb},  {7'b0, e.e_ws});
        end
        vec_idx++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] a5, a7, a9;
        bus.a = 16'h0000; bus.din = 8'h00; bus.reg_rdata = 8'h00;
        bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //             rst op    a         din    rdata   dout  oe  addr  chg wd     rd rs ws
        tbl.push_back(mk(0, OP_I, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_O, 16'hFC3B, 8'h42, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_O, 16'hFC3B, 8'h42, 8'h00, 8'h42, 0, 8'h42, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_O, 16'hFC3B, 8'h42, 8'h00, 8'h42, 0, 8'h42, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_O, 16'hFC3B, 8'h42, 8'h00, 8'h42, 0, 8'h42, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, 8'h42, 0, 8'h42, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_N, 16'hFC3B, 8'h00, 8'h00, 8'h42, 1, 8'h42, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, 8'h42, 0, 8'h42, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_O, 16'hFD3B, 8'h5A, 8'h00, 8'h42, 0, 8'h42, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_O, 16'hFD3B, 8'h5A, 8'h00, 8'h42, 0, 8'h42, 0, 8'h5A, 0, 0, 1));
        tbl.push_back(mk(1, OP_O, 16'hFD3B, 8'h5A, 8'h00, 8'h42, 0, 8'h42, 0, 8'h5A, 0, 0, 0));
        tbl.push_back(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, 8'h42, 0, 8'h42, 0, 8'h5A, 0, 0, 0));
        tbl.push_back(mk(1, OP_N, 16'hFD3B, 8'h00, 8'hC3, 8'hC3, 1, 8'h42, 0, 8'h5A, 1, 0, 0));
        tbl.push_back(mk(1, OP_N, 16'hFD3B, 8'h00, 8'hC3, 8'hC3, 1, 8'h42, 0, 8'h5A, 1, 1, 0));
        tbl.push_back(mk(1, OP_I, 16'h0000, 8'h00, 8'hC3, 8'h42, 0, 8'h42, 0, 8'h5A, 0, 0, 0));
        tbl.push_back(mk(1, OP_O, 16'hFD3B, 8'h11, 8'h00, 8'h42, 0, 8'h42, 0, 8'h5A, 0, 0, 0));
        tbl.push_back(mk(0, OP_O, 16'hFD3B, 8'h11, 8'h00, 8'h42, 0, 8'h42, 0, 8'h11, 0, 0, 1));
        tbl.push_back(mk(0, OP_O, 16'hFD3B, 8'h11, 8'h00, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_O, 16'hFD3B, 8'h11, 8'h00, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, OP_O, 16'hFD3B, 8'h11, 8'h00, 8'h00, 0, 8'h00, 0, 8'h11, 0, 0, 1));
        tbl.push_back(mk(1, OP_O, 16'hFD3B, 8'h11, 8'h00, 8'h00, 0, 8'h00, 0, 8'h11, 0, 0, 0));
        tbl.push_back(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 8'h11, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Auto-increment block read across the FF->00 wrap, then index write vs. increment.
        a5 = AI ? 8'hFF : 8'hFE;
        a7 = AI ? 8'h00 : 8'hFE;
        a9 = AI ? 8'h01 : 8'hFE;
        step(mk(1, OP_O, 16'hFE3B, 8'h01, 8'h00, 8'h00, 0, 8'h00, 0,  8'h11, 0, 0, 0));
        step(mk(1, OP_O, 16'hFC3B, 8'hFE, 8'h00, 8'h00, 0, 8'h00, 0,  8'h11, 0, 0, 0));
        step(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, 8'hFE, 0, 8'hFE, 1,  8'h11, 0, 0, 0));
        step(mk(1, OP_N, 16'hFD3B, 8'h00, 8'h77, 8'h77, 1, 8'hFE, 0,  8'h11, 1, 0, 0));
        step(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, 8'hFE, 0, 8'hFE, 0,  8'h11, 0, 1, 0));
        step(mk(1, OP_N, 16'hFD3B, 8'h00, 8'h77, 8'h77, 1, a5,    AI, 8'h11, 1, 0, 0));
        step(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, a5,    0, a5,    0,  8'h11, 0, 1, 0));
        step(mk(1, OP_N, 16'hFD3B, 8'h00, 8'h77, 8'h77, 1, a7,    AI, 8'h11, 1, 0, 0));
        step(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, a7,    0, a7,    0,  8'h11, 0, 1, 0));
        step(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, a9,    0, a9,    AI, 8'h11, 0, 0, 0));
        step(mk(1, OP_N, 16'hFE3B, 8'h00, 8'h00, a9,    AI, a9,   0,  8'h11, 0, 0, 0));
        step(mk(1, OP_N, 16'hFD3B, 8'h00, 8'h77, 8'h77, 1, a9,    0,  8'h11, 1, 0, 0));
        step(mk(1, OP_O, 16'hFC3B, 8'h80, 8'h00, a9,    0, a9,    0,  8'h11, 0, 1, 0));
        step(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, 8'h80, 0, 8'h80, 1,  8'h11, 0, 0, 0));
        step(mk(1, OP_I, 16'h0000, 8'h00, 8'h00, 8'h80, 0, 8'h80, 0,  8'h11, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
